// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point sizing for the neural-network layer, LUT and activation blocks.
package nn_fixed_pkg;

  localparam int NN_DATA_W  = 8;
  localparam int NN_ADDR_W  = 4;
  localparam int NN_FRAC_W  = 4;
  localparam int NN_COUNT_W = 16;

endpackage

// File: rtl/interp_datapath.sv
// Linear interpolation between two LUT entries: base + floor(diff * frac / 2^FRAC_W).
module interp_datapath #(
  parameter int DATA_W = 8,
  parameter int FRAC_W = 4
) (
  input  logic signed [DATA_W-1:0] base,
  input  logic signed [DATA_W:0]   diff,
  input  logic        [FRAC_W-1:0] frac,
  output logic signed [DATA_W-1:0] result
);

  localparam int PROD_W = DATA_W + FRAC_W + 2;

  logic signed [PROD_W-1:0] diff_x;
  logic signed [PROD_W-1:0] frac_x;
  logic signed [PROD_W-1:0] base_x;
  logic signed [PROD_W-1:0] product;
  logic signed [PROD_W-1:0] scaled;

  always_comb begin
    diff_x  = {{(PROD_W-DATA_W-1){diff[DATA_W]}}, diff};
    frac_x  = {{(PROD_W-FRAC_W){1'b0}}, frac};
    base_x  = {{(PROD_W-DATA_W){base[DATA_W-1]}}, base};
    product = diff_x * frac_x;
    scaled  = product >>> FRAC_W;
    // result lies between base and next entry, so dropping the upper bits is exact
    result  = DATA_W'(base_x + scaled);
  end

endmodule

// File: rtl/activation_interpolator.sv
// Three-stage LUT-based activation: address/fraction register, LUT capture, interpolate.
module activation_interpolator
  import nn_fixed_pkg::*;
#(
  parameter int DATA_W = NN_DATA_W,
  parameter int ADDR_W = NN_ADDR_W,
  parameter int FRAC_W = NN_FRAC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic        [ADDR_W-1:0] lut_address,
  input  logic signed [DATA_W-1:0] lut_base,
  input  logic signed [DATA_W-1:0] lut_next,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic [NN_COUNT_W-1:0]    out_count
);

  logic                     live;
  logic                     en;
  logic                     s1_valid;
  logic        [ADDR_W-1:0] s1_addr;
  logic        [FRAC_W-1:0] s1_frac;
  logic                     s2_valid;
  logic signed [DATA_W-1:0] s2_base;
  logic signed [DATA_W:0]   s2_diff;
  logic        [FRAC_W-1:0] s2_frac;
  logic signed [DATA_W-1:0] interp_result;

  // Whole pipeline freezes while the output register is blocked.
  assign en          = !(out_valid && !out_ready);
  assign in_ready    = en && live;
  assign lut_address = s1_addr;

  interp_datapath #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_datapath (
    .base   (s2_base),
    .diff   (s2_diff),
    .frac   (s2_frac),
    .result (interp_result)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      live      <= 1'b0;
      s1_valid  <= 1'b0;
      s1_addr   <= '0;
      s1_frac   <= '0;
      s2_valid  <= 1'b0;
      s2_base   <= '0;
      s2_diff   <= '0;
      s2_frac   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
    end else begin
      live <= 1'b1;
      if (en) begin
        s1_valid <= in_valid && in_ready;
        if (in_valid && in_ready) begin
          s1_addr <= in_data[DATA_W-1:DATA_W-ADDR_W];
          s1_frac <= in_data[FRAC_W-1:0];
        end
        s2_valid  <= s1_valid;
        s2_base   <= lut_base;
        s2_diff   <= {lut_next[DATA_W-1], lut_next} - {lut_base[DATA_W-1], lut_base};
        s2_frac   <= s1_frac;
        out_valid <= s2_valid;
        if (s2_valid) begin
          out_data <= interp_result;
        end
      end
      if (out_valid && out_ready) begin
        out_count <= out_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_activation_interpolator.sv
// Bench for activation_interpolator: directed cases plus randomized traffic against a queue-based model.
module tb_activation_interpolator;
  import nn_fixed_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [7:0] in_data = '0;
  logic        [3:0] lut_address;
  logic signed [7:0] lut_base;
  logic signed [7:0] lut_next;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic signed [7:0] out_data;
  logic       [15:0] out_count;

  logic signed [7:0] lut [16];

  int errors = 0;
  int checks = 0;
  int q[$];
  int exp_count = 0;
  int accepted = 0;
  bit prev_stall = 1'b0;
  int prev_data = 0;

  activation_interpolator #(
    .DATA_W (8),
    .ADDR_W (4),
    .FRAC_W (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .lut_address (lut_address),
    .lut_base    (lut_base),
    .lut_next    (lut_next),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_count   (out_count)
  );

  always #5 clk = ~clk;

  // External LUT: address 7 clamps to itself, address 15 wraps to entry 0.
  always_comb begin
    lut_base = lut[lut_address];
    lut_next = (lut_address == 4'd7) ? lut[7] : lut[lut_address + 4'd1];
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_out(input logic [7:0] d);
    int a, f, b, n, p, fl;
    a = int'(d[7:4]);
    f = int'(d[3:0]);
    b = lut[a];
    n = (a == 7) ? lut[7] : lut[(a + 1) % 16];
    p = (n - b) * f;
    fl = (p >= 0) ? p / 16 : -((-p + 15) / 16);
    return b + fl;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ramp_lut();
    for (int i = 0; i < 16; i++) lut[i] = (i < 8) ? 8'(i * 16) : 8'sd0;
  endtask

  task automatic wait_out(input string tag);
    int n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check(tag, int'(out_valid), 1);
  endtask

  // Monitor: scoreboards every accepted input and every output transfer.
  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
      exp_count = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", int'(out_valid), 1);
        check("stall_hold", int'(out_data), prev_data);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("spurious_out", int'(out_valid), 0);
        else check("out_data", int'(out_data), q.pop_front());
        exp_count = (exp_count + 1) % 65536;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_out(in_data));
        accepted++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data = int'(out_data);
    end
  end

  task automatic run_random(input int n_inputs, input int max_cycles);
    int start = accepted;
    int cyc = 0;
    while (accepted - start < n_inputs && cyc < max_cycles) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      cyc++;
    end
    check("rand_accepted", accepted - start, n_inputs);
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (q.size() > 0 && cyc < 50) begin
      tick();
      cyc++;
    end
    tick();
    check("rand_drain", q.size(), 0);
    check("rand_count", int'(out_count), exp_count);
  endtask

  initial begin
    int lat;
    load_ramp_lut();

    // Reset state
    rst = 1'b0;
    tick();
    tick();
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_count", int'(out_count), 0);
    rst = 1'b1;
    tick();
    check("ready_after_rst", int'(in_ready), 1);

    // Single input, latency and count
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h23;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", lat, 3);
    check("x23_data", int'(out_data), 35);
    tick();
    check("x23_count", int'(out_count), 1);

    // Back-to-back with address-7 clamp
    in_valid = 1'b1;
    in_data = 8'h68;
    tick();
    in_data = 8'h7F;
    tick();
    in_valid = 1'b0;
    wait_out("x68_valid");
    check("x68_data", int'(out_data), 104);
    tick();
    check("x7f_valid", int'(out_valid), 1);
    check("x7f_data", int'(out_data), 112);
    tick();

    // Address-15 wrap and zero input
    in_valid = 1'b1;
    in_data = 8'hF8;
    tick();
    in_data = 8'h00;
    tick();
    in_valid = 1'b0;
    wait_out("xf8_valid");
    check("xf8_data", int'(out_data), 0);
    tick();
    check("x00_valid", int'(out_valid), 1);
    check("x00_data", int'(out_data), 0);
    tick();
    check("count_5", int'(out_count), 5);

    // Stall with three results queued
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h10;
    tick();
    in_data = 8'h21;
    tick();
    in_data = 8'h32;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_in_ready", int'(in_ready), 0);
      check("stall_data16", int'(out_data), 16);
      tick();
    end
    out_ready = 1'b1;
    check("drain0", int'(out_data), ref_out(8'h10));
    tick();
    check("drain1_valid", int'(out_valid), 1);
    check("drain1", int'(out_data), ref_out(8'h21));
    tick();
    check("drain2_valid", int'(out_valid), 1);
    check("drain2", int'(out_data), ref_out(8'h32));
    tick();
    check("drain_empty", int'(out_valid), 0);

    // Reset with two results in flight
    in_valid = 1'b1;
    in_data = 8'h23;
    tick();
    in_data = 8'h45;
    tick();
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    check("flush_valid", int'(out_valid), 0);
    check("flush_data", int'(out_data), 0);
    check("flush_count", int'(out_count), 0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("flush_no_out", int'(out_valid), 0);
    end

    // Randomized traffic, ramp LUT then arbitrary LUT contents
    run_random(10000, 60000);
    for (int i = 0; i < 16; i++) lut[i] = 8'($urandom);
    run_random(2000, 12000);
    load_ramp_lut();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
